prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
Upstream stage of the single-cycle CPU. Accepts a word stream (program/data image, then initial register values) over a valid/ready handshake and writes it into the unified IMEM/DMEM image and the register file. Holds the CPU in reset until the load is complete, then releases it and watches `halt` to report completion. This replaces the simulator-only hex-file preload with synthesizable loading.

Parameters:
- MEM_WORDS, 1024, depth of the memory image in 32-bit words (memory-phase word limit).
- MEM_BASE, 32'h0000_0000, byte address of the first memory word.
- RF_WORDS, 32, number of register words expected in the register phase (x0 included).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERR.
- in_valid  in  1  stream word valid.
- in_data  in  32  stream word.
- in_last  in  1  marks the final word of the memory phase.
- in_ready  out  1  loader can accept a word.
- mem_we  out  1  memory write strobe (drives both IMEM and DMEM).
- mem_addr  out  32  byte address of the memory write.
- mem_wdata  out  32  memory write data.
- rf_we  out  1  register-file write strobe.
- rf_addr  out  5  register index.
- rf_wdata  out  32  register write data.
- cpu_rst  out  1  active-low reset to the CPU; 0 = CPU held in reset.
- halt  in  1  halt from the CPU.
- busy  out  1  high in MEM, REGS or CHK.
- done  out  1  high in DONE.
- error  out  1  high in ERR.

Behaviour:
- On reset: state=IDLE; all of the following are 0: in_ready, mem_we, rf_we, cpu_rst, busy, done, error. Address/data outputs are 0; word index and checksum are 0.
- A handshake occurs on a clock edge where in_valid && in_ready. in_ready is 1 only in MEM, REGS and CHK; it is a registered state decode with no combinational path from in_valid.
- IDLE:
  - start → MEM; index cleared.
- MEM, on each handshake:
  - next cycle: mem_we=1 for exactly one cycle, mem_addr=MEM_BASE+4*idx, mem_wdata=word; idx increments (1-cycle write latency).
  - in_last on the handshake → REGS, idx cleared.
  - if the handshake is on idx==MEM_WORDS-1 without in_last, the word is still written, then → ERR.
- REGS, on each handshake:
  - next cycle: rf_we=1 for exactly one cycle, rf_addr=idx[4:0], rf_wdata=word. rf_we is suppressed when idx==0, so x0 is never written, but the word is still consumed.
  - after word RF_WORDS-1 → CHK if LOADER_CHECKSUM_EN is defined, else → RUN.
  - in_last asserted during REGS → ERR; that word is not written.
- RUN:
  - cpu_rst=1, the first cycle after the last write completes.
  - halt sampled high → DONE; cpu_rst stays 1 so state can be inspected.
- DONE / ERR:
  - cpu_rst=0 in ERR.
  - start → MEM; idx and checksum cleared.
- start is ignored in MEM, REGS, CHK and RUN.
- in_valid outside the accepting states is ignored; no write occurs.
- Async reset mid-load aborts immediately: outputs return to reset values, and partially written memory is not restored.
- Address arithmetic is modulo 2^32.

Optional Feature:
LOADER_CHECKSUM_EN:
- Defined:
  - a 32-bit XOR checksum of every accepted MEM and REGS word is accumulated;
  - CHK state accepts one word;
  - equal to the checksum → RUN, else → ERR;
  - port chk_value out 32 exposes the running checksum.
- Undefined: no CHK state, no chk_value port; REGS goes directly to RUN.

Decomposition:
- Shared package `loader_pkg`:
  - state enum {IDLE, MEM, REGS, CHK, RUN, DONE, ERR};
  - RF_IDX_W=5;
  - WORD_W=32.
- One natural sub-module: `loader_wr_stage`, the registered write-strobe/address/data stage shared by the memory and register-file paths. The FSM stays in the top level.

Test Plan:
- Reset with rst=0 → in_ready=0, cpu_rst=0, state IDLE. Then start, 3 MEM words 0x00000013/0x00100093/0x00000073 with last on the third → mem writes at 0x0, 0x4, 0x8.
- Continue with 32 REGS words 0..31 → rf_we asserted for idx 1..31 only (31 writes), x5 receives 5. cpu_rst rises the cycle after the x31 write; halt=1 → done=1.
- in_valid toggling randomly and back-to-back handshakes → no dropped or duplicated writes; address sequence is contiguous.
- MEM_WORDS=4 override, 4 words with no last → 4 writes, then error=1 and cpu_rst stays 0. start → busy=1 again.
- in_last on REGS word 10 → error=1, no write to x10.
- With LOADER_CHECKSUM_EN defined:
  - correct XOR word → RUN;
  - checksum^1 → ERR, cpu_rst=0.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types for the program loader: FSM state encoding and word widths.
package loader_pkg;
  localparam int RF_IDX_W = 5;
  localparam int WORD_W   = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MEM  = 3'd1,
    REGS = 3'd2,
    CHK  = 3'd3,
    RUN  = 3'd4,
    DONE = 3'd5,
    ERR  = 3'd6
  } state_t;

  function automatic logic accepting(input state_t s);
    return (s == MEM) || (s == REGS) || (s == CHK);
  endfunction
endpackage

// File: rtl/loader_wr_stage.sv
// Registered write stage shared by the memory-image and register-file paths.
// Strobes last one cycle per request; address/data hold their last value.
module loader_wr_stage
  import loader_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_req,
  input  logic [WORD_W-1:0]   mem_addr_d,
  input  logic                rf_req,
  input  logic [RF_IDX_W-1:0] rf_addr_d,
  input  logic [WORD_W-1:0]   wdata_d,
  output logic                mem_we,
  output logic [WORD_W-1:0]   mem_addr,
  output logic [WORD_W-1:0]   mem_wdata,
  output logic                rf_we,
  output logic [RF_IDX_W-1:0] rf_addr,
  output logic [WORD_W-1:0]   rf_wdata
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rf_we     <= 1'b0;
      rf_addr   <= '0;
      rf_wdata  <= '0;
    end else begin
      mem_we <= mem_req;
      rf_we  <= rf_req;
      if (mem_req) begin
        mem_addr  <= mem_addr_d;
        mem_wdata <= wdata_d;
      end
      if (rf_req) begin
        rf_addr  <= rf_addr_d;
        rf_wdata <= wdata_d;
      end
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Streams a memory image and initial register values into the CPU, holding it
// in reset until loaded. Optional checksum phase: define LOADER_CHECKSUM_EN.
//
// state | meaning
// IDLE  | waiting for start, CPU held in reset
// MEM   | accepting memory-image words
// REGS  | accepting register words (x0 consumed, not written)
// CHK   | accepting one checksum word
// RUN   | CPU released, watching halt
// DONE  | CPU halted, left out of reset for inspection
// ERR   | load failed, CPU held in reset
module prog_loader
  import loader_pkg::*;
#(
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] MEM_BASE  = 32'h0000_0000,
  parameter int          RF_WORDS  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                in_valid,
  input  logic [WORD_W-1:0]   in_data,
  input  logic                in_last,
  output logic                in_ready,
  output logic                mem_we,
  output logic [WORD_W-1:0]   mem_addr,
  output logic [WORD_W-1:0]   mem_wdata,
  output logic                rf_we,
  output logic [RF_IDX_W-1:0] rf_addr,
  output logic [WORD_W-1:0]   rf_wdata,
  output logic                cpu_rst,
  input  logic                halt,
  output logic                busy,
  output logic                done,
  output logic                error
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [WORD_W-1:0]   chk_value
`endif
);

  state_t            state, state_nx;
  logic [31:0]       idx, idx_nx;
  logic [WORD_W-1:0] chk, chk_nx;
  logic              mem_req, rf_req;
  logic              hs;

  assign hs = in_valid && in_ready;

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    chk_nx   = chk;
    mem_req  = 1'b0;
    rf_req   = 1'b0;
    case (state)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_nx = MEM;
          idx_nx   = '0;
          chk_nx   = '0;
        end
      end
      MEM: begin
        if (hs) begin
          mem_req = 1'b1;
          chk_nx  = chk ^ in_data;
          if (in_last) begin
            state_nx = REGS;
            idx_nx   = '0;
          end else begin
            idx_nx = idx + 32'd1;
            if (idx == 32'(MEM_WORDS - 1)) state_nx = ERR;
          end
        end
      end
      REGS: begin
        if (hs) begin
          // in_last belongs to the memory phase; seeing it here means a malformed stream
          if (in_last) begin
            state_nx = ERR;
          end else begin
            rf_req = (idx != 32'd0);
            chk_nx = chk ^ in_data;
            idx_nx = idx + 32'd1;
            if (idx == 32'(RF_WORDS - 1)) begin
`ifdef LOADER_CHECKSUM_EN
              state_nx = CHK;
`else
              state_nx = RUN;
`endif
            end
          end
        end
      end
      CHK: begin
`ifdef LOADER_CHECKSUM_EN
        if (hs) state_nx = (in_data == chk) ? RUN : ERR;
`else
        state_nx = ERR;
`endif
      end
      RUN: begin
        if (cpu_rst && halt) state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      idx      <= '0;
      chk      <= '0;
      in_ready <= 1'b0;
      cpu_rst  <= 1'b0;
    end else begin
      state    <= state_nx;
      idx      <= idx_nx;
      chk      <= chk_nx;
      in_ready <= accepting(state_nx);
      // rises one cycle after RUN entry so the final write lands before release
      cpu_rst  <= ((state == RUN) || (state == DONE)) &&
                  ((state_nx == RUN) || (state_nx == DONE));
    end
  end

  loader_wr_stage u_wr (
    .clk        (clk),
    .rst        (rst),
    .mem_req    (mem_req),
    .mem_addr_d (MEM_BASE + {idx[29:0], 2'b00}),
    .rf_req     (rf_req),
    .rf_addr_d  (idx[RF_IDX_W-1:0]),
    .wdata_d    (in_data),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .rf_we      (rf_we),
    .rf_addr    (rf_addr),
    .rf_wdata   (rf_wdata)
  );

  assign busy  = accepting(state);
  assign done  = (state == DONE);
  assign error = (state == ERR);

`ifdef LOADER_CHECKSUM_EN
  assign chk_value = chk;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader (MEM_WORDS overridden to 4).
module tb_prog_loader;
  logic        clk, rst, start, in_valid, in_last, halt;
  logic [31:0] in_data;
  logic        in_ready, mem_we, rf_we, cpu_rst, busy, done, error;
  logic [31:0] mem_addr, mem_wdata, rf_wdata;
  logic [4:0]  rf_addr;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] chk_value;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem_a_q[$];
  logic [31:0] mem_d_q[$];
  logic [4:0]  rf_a_q[$];
  logic [31:0] rf_d_q[$];

  prog_loader #(.MEM_WORDS(4), .MEM_BASE(32'h0), .RF_WORDS(32)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
    .cpu_rst(cpu_rst), .halt(halt), .busy(busy), .done(done), .error(error)
`ifdef LOADER_CHECKSUM_EN
    , .chk_value(chk_value)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) begin
      mem_a_q.push_back(mem_addr);
      mem_d_q.push_back(mem_wdata);
    end
    if (rf_we) begin
      rf_a_q.push_back(rf_addr);
      rf_d_q.push_back(rf_wdata);
    end
  end

  task automatic clear_logs();
    mem_a_q.delete(); mem_d_q.delete(); rf_a_q.delete(); rf_d_q.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (!in_ready) begin
      n_fail++;
      $display("FAIL send_timeout: in_ready=%0b want 1 for word %h", in_ready, d);
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; halt = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_checks++; if (cpu_rst !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_rst: got %b want 0", cpu_rst); end
    n_checks++; if ({busy, done, error} !== 3'b000) begin n_fail++; $display("FAIL reset_status: got %b want 000", {busy, done, error}); end
    n_checks++; if ({mem_we, rf_we} !== 2'b00) begin n_fail++; $display("FAIL reset_we: got %b want 00", {mem_we, rf_we}); end
    n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mem_load();
    logic [31:0] exp_d[3];
    exp_d[0] = 32'h0000_0013; exp_d[1] = 32'h0010_0093; exp_d[2] = 32'h0000_0073;
    clear_logs();
    pulse_start();
    n_checks++; if ({busy, in_ready} !== 2'b11) begin n_fail++; $display("FAIL mem_start: busy,in_ready=%b want 11", {busy, in_ready}); end
    for (int i = 0; i < 3; i++) send(exp_d[i], i == 2);
    repeat (2) @(negedge clk);
    n_checks++; if (mem_a_q.size() != 3) begin n_fail++; $display("FAIL mem_count: got %0d want 3", mem_a_q.size()); end
    for (int i = 0; i < 3 && i < mem_a_q.size(); i++) begin
      n_checks++;
      if (mem_a_q[i] !== 32'(i * 4) || mem_d_q[i] !== exp_d[i]) begin
        n_fail++;
        $display("FAIL mem_write%0d: got %h/%h want %h/%h", i, mem_a_q[i], mem_d_q[i], 32'(i * 4), exp_d[i]);
      end
    end
  endtask

  task automatic test_regs_load();
    for (int i = 0; i < 32; i++) send(32'(i), 1'b0);
    n_checks++;
    if (rf_we !== 1'b1 || rf_addr !== 5'd31 || rf_wdata !== 32'd31) begin
      n_fail++; $display("FAIL x31_write: got we=%b a=%0d d=%h want 1/31/1f", rf_we, rf_addr, rf_wdata);
    end
`ifdef LOADER_CHECKSUM_EN
    n_checks++; if (chk_value !== 32'h0010_00F3) begin n_fail++; $display("FAIL chk_value: got %h want 001000f3", chk_value); end
    send(32'h0010_00F3, 1'b0);
`endif
    n_checks++; if (cpu_rst !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL run_entry: cpu_rst=%b in_ready=%b want 0/0", cpu_rst, in_ready); end
    @(negedge clk);
    n_checks++; if (cpu_rst !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL run_release: cpu_rst=%b busy=%b want 1/0", cpu_rst, busy); end
    @(negedge clk);
    n_checks++; if (rf_a_q.size() != 31) begin n_fail++; $display("FAIL rf_count: got %0d want 31", rf_a_q.size()); end
    n_checks++; if (rf_a_q[0] !== 5'd1) begin n_fail++; $display("FAIL rf_first: got %0d want 1", rf_a_q[0]); end
    n_checks++; if (rf_a_q[4] !== 5'd5 || rf_d_q[4] !== 32'd5) begin n_fail++; $display("FAIL x5: got a=%0d d=%h want 5/5", rf_a_q[4], rf_d_q[4]); end
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    n_checks++; if (done !== 1'b1 || cpu_rst !== 1'b1) begin n_fail++; $display("FAIL halt_done: done=%b cpu_rst=%b want 1/1", done, cpu_rst); end
    @(negedge clk);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL done_hold: got %b want 1", done); end
  endtask

  task automatic test_ignored();
    int nm, nr;
    nm = mem_a_q.size(); nr = rf_a_q.size();
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL idle_ready: got %b want 0", in_ready); end
    n_checks++;
    if (mem_a_q.size() != nm || rf_a_q.size() != nr) begin
      n_fail++; $display("FAIL idle_writes: got %0d/%0d want %0d/%0d", mem_a_q.size(), rf_a_q.size(), nm, nr);
    end
  endtask

  task automatic test_back_to_back();
    clear_logs();
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      send(32'hA0 + 32'(i), i == 3);
      if (i == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    n_checks++; if (mem_a_q.size() != 4) begin n_fail++; $display("FAIL b2b_count: got %0d want 4", mem_a_q.size()); end
    for (int i = 0; i < 4 && i < mem_a_q.size(); i++) begin
      n_checks++;
      if (mem_a_q[i] !== 32'(i * 4) || mem_d_q[i] !== 32'hA0 + 32'(i)) begin
        n_fail++;
        $display("FAIL b2b_write%0d: got %h/%h want %h/%h", i, mem_a_q[i], mem_d_q[i], 32'(i * 4), 32'hA0 + 32'(i));
      end
    end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %b want 1", busy); end
  endtask

  task automatic test_async_abort();
    send(32'h0, 1'b0);
    send(32'h1234, 1'b0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({busy, in_ready, cpu_rst, error} !== 4'b0000 || rf_addr !== 5'd0 || rf_wdata !== 32'h0 || mem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL async_abort: busy=%b rdy=%b rf_a=%0d rf_d=%h mem_a=%h want all 0", busy, in_ready, rf_addr, rf_wdata, mem_addr);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mem_overflow();
    clear_logs();
    pulse_start();
    for (int i = 0; i < 4; i++) send(32'hB0 + 32'(i), 1'b0);
    n_checks++;
    if (error !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'hC) begin
      n_fail++; $display("FAIL ovf_last: error=%b we=%b a=%h want 1/1/c", error, mem_we, mem_addr);
    end
    repeat (2) @(negedge clk);
    n_checks++; if (mem_a_q.size() != 4) begin n_fail++; $display("FAIL ovf_count: got %0d want 4", mem_a_q.size()); end
    n_checks++;
    if ({error, cpu_rst, in_ready, busy} !== 4'b1000) begin
      n_fail++; $display("FAIL ovf_state: err,cpu_rst,rdy,busy=%b want 1000", {error, cpu_rst, in_ready, busy});
    end
    pulse_start();
    n_checks++; if (busy !== 1'b1 || error !== 1'b0) begin n_fail++; $display("FAIL ovf_restart: busy=%b error=%b want 1/0", busy, error); end
  endtask

  task automatic test_regs_last_err();
    clear_logs();
    send(32'h11, 1'b1);
    for (int i = 0; i < 10; i++) send(32'(i), 1'b0);
    send(32'd10, 1'b1);
    repeat (2) @(negedge clk);
    n_checks++; if (error !== 1'b1 || cpu_rst !== 1'b0) begin n_fail++; $display("FAIL rlast_err: error=%b cpu_rst=%b want 1/0", error, cpu_rst); end
    n_checks++; if (rf_a_q.size() != 9) begin n_fail++; $display("FAIL rlast_count: got %0d want 9", rf_a_q.size()); end
    n_checks++; if (rf_a_q[8] !== 5'd9) begin n_fail++; $display("FAIL rlast_addr: got %0d want 9", rf_a_q[8]); end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    pulse_start();
    send(32'h55, 1'b1);
    for (int i = 0; i < 32; i++) send(32'(i), 1'b0);
    n_checks++; if (chk_value !== 32'h55) begin n_fail++; $display("FAIL chk_run: got %h want 55", chk_value); end
    send(32'h54, 1'b0);
    @(negedge clk);
    n_checks++; if (error !== 1'b1 || cpu_rst !== 1'b0) begin n_fail++; $display("FAIL chk_bad: error=%b cpu_rst=%b want 1/0", error, cpu_rst); end
    pulse_start();
    send(32'h55, 1'b1);
    for (int i = 0; i < 32; i++) send(32'(i), 1'b0);
    send(32'h55, 1'b0);
    repeat (2) @(negedge clk);
    n_checks++; if (cpu_rst !== 1'b1 || error !== 1'b0) begin n_fail++; $display("FAIL chk_good: cpu_rst=%b error=%b want 1/0", cpu_rst, error); end
  endtask
`endif

  initial begin
    test_reset();
    test_mem_load();
    test_regs_load();
    test_ignored();
    test_back_to_back();
    test_async_abort();
    test_mem_overflow();
    test_regs_last_err();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
